// File: rtl/pkg_ili9341.sv
// Shared types and constants for the ILI9341 init sequencer.
//   entry_t    : ROM entry layout {is_delay, dc, payload}
//   state_t    : sequencer states
//   CMD / DAT  : dc values for command and data bytes
//   END_MARK   : end-of-table entry (delay of zero)
//   DELAY_MS   : builds a delay entry of n ticks
//   INIT_TABLE : default power-on table for an external ROM
package pkg_ili9341;

    localparam int unsigned PAYLOAD_W = 8;
    localparam int unsigned N_INIT    = 47;

    typedef struct packed {
        logic                 is_delay;
        logic                 dc;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    typedef enum logic [3:0] {
        IDLE, HW_RST, HW_WAIT, FETCH, DECODE, SEND, DELAY, ADVANCE, DONE
    } state_t;

    localparam logic   CMD      = 1'b0;
    localparam logic   DAT      = 1'b1;
    localparam entry_t END_MARK = '{is_delay: 1'b1, dc: CMD, payload: 8'h00};

    function automatic entry_t DELAY_MS(input logic [PAYLOAD_W-1:0] n);
        return '{is_delay: 1'b1, dc: CMD, payload: n};
    endfunction

    function automatic entry_t cmd_byte(input logic [PAYLOAD_W-1:0] b);
        return '{is_delay: 1'b0, dc: CMD, payload: b};
    endfunction

    function automatic entry_t dat_byte(input logic [PAYLOAD_W-1:0] b);
        return '{is_delay: 1'b0, dc: DAT, payload: b};
    endfunction

    // Power control, timing, VCOM, MADCTL, 16 bpp, frame rate, then wake-up.
    localparam entry_t INIT_TABLE [N_INIT] = '{
        cmd_byte(8'hCF), dat_byte(8'h00), dat_byte(8'hC1), dat_byte(8'h30),
        cmd_byte(8'hED), dat_byte(8'h64), dat_byte(8'h03), dat_byte(8'h12), dat_byte(8'h81),
        cmd_byte(8'hE8), dat_byte(8'h85), dat_byte(8'h00), dat_byte(8'h78),
        cmd_byte(8'hCB), dat_byte(8'h39), dat_byte(8'h2C), dat_byte(8'h00), dat_byte(8'h34),
        dat_byte(8'h02),
        cmd_byte(8'hF7), dat_byte(8'h20),
        cmd_byte(8'hC0), dat_byte(8'h23),
        cmd_byte(8'hC1), dat_byte(8'h10),
        cmd_byte(8'hC5), dat_byte(8'h3E), dat_byte(8'h28),
        cmd_byte(8'hC7), dat_byte(8'h86),
        cmd_byte(8'h36), dat_byte(8'h48),
        cmd_byte(8'h3A), dat_byte(8'h55),
        cmd_byte(8'hB1), dat_byte(8'h00), dat_byte(8'h18),
        cmd_byte(8'hB6), dat_byte(8'h08), dat_byte(8'h82), dat_byte(8'h27),
        cmd_byte(8'h13),
        cmd_byte(8'h11), DELAY_MS(8'd120),
        cmd_byte(8'h29), DELAY_MS(8'd20),
        END_MARK
    };

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter with zero flag; times reset pulse, post-reset wait and delays.
//   clk, rst : clock, synchronous active-high reset
//   load     : load value on the next edge (wins over counting)
//   value    : load value
//   zero_c   : count is zero (decoded from the count register)
module lcd_delay_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero_c
);

    logic [WIDTH-1:0] count;

    // Counts down and parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/lcd_init_sequencer.sv
// Panel init sequencer: pulses the panel reset, then walks an external command
// ROM and hands command/data bytes to the serializer over valid/ready.
//   clk, rst  : clock, synchronous active-high reset
//   start     : pulse; begins a sequence from IDLE or DONE
//   rom_addr  : ROM entry index; rom_data : {is_delay, dc, payload}, one cycle later
//   tx_valid, tx_ready, tx_data, tx_dc : byte handshake to the serializer
//   lcd_rst_n : panel hardware reset, active low
//   busy, done: sequence running / sequence completed
module lcd_init_sequencer
    import pkg_ili9341::*;
#(
    parameter int unsigned N_ENTRIES    = 47,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DELAY_UNIT   = 100000,
    parameter int unsigned RST_LOW_CYC  = 1000,
    parameter int unsigned RST_WAIT_CYC = 500000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [$clog2(N_ENTRIES)-1:0] rom_addr,
    input  logic [DATA_W+1:0]            rom_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         tx_dc,
    output logic                         lcd_rst_n,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned ADDR_W = $clog2(N_ENTRIES);
    // Wide enough for payload*DELAY_UNIT and for both reset timings.
    localparam int unsigned MUL_W  = DATA_W + $clog2(DELAY_UNIT + 1);
    localparam int unsigned RST_W  = $clog2((RST_WAIT_CYC > RST_LOW_CYC ? RST_WAIT_CYC : RST_LOW_CYC) + 1);
    localparam int unsigned CNT_W  = (MUL_W > RST_W) ? MUL_W : RST_W;

    state_t              state;
    logic                cnt_load_c;
    logic [CNT_W-1:0]    cnt_value_c;
    logic                cnt_zero_c;
    logic                is_delay_c;
    logic                dc_c;
    logic [DATA_W-1:0]   payload_c;
    logic [CNT_W-1:0]    delay_load_c;

    assign is_delay_c   = rom_data[DATA_W+1];
    assign dc_c         = rom_data[DATA_W];
    assign payload_c    = rom_data[DATA_W-1:0];
    // Counter is loaded with length-1 so each phase lasts exactly its length.
    assign delay_load_c = CNT_W'(payload_c) * CNT_W'(DELAY_UNIT) - CNT_W'(1);

    // Counter loads on entry to HW_RST, HW_WAIT and DELAY.
    always_comb begin
        cnt_load_c  = 1'b0;
        cnt_value_c = '0;
        if ((state == IDLE || state == DONE) && start) begin
            cnt_load_c  = 1'b1;
            cnt_value_c = CNT_W'(RST_LOW_CYC - 1);
        end else if (state == HW_RST && cnt_zero_c) begin
            cnt_load_c  = 1'b1;
            cnt_value_c = CNT_W'(RST_WAIT_CYC - 1);
        end else if (state == DECODE && is_delay_c && payload_c != '0) begin
            cnt_load_c  = 1'b1;
            cnt_value_c = delay_load_c;
        end
    end

    lcd_delay_counter #(.WIDTH(CNT_W)) u_delay (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load_c),
        .value  (cnt_value_c),
        .zero_c (cnt_zero_c)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rom_addr  <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            tx_dc     <= 1'b0;
            lcd_rst_n <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= HW_RST;
                        lcd_rst_n <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                HW_RST: begin
                    if (cnt_zero_c) begin
                        state     <= HW_WAIT;
                        lcd_rst_n <= 1'b1;
                    end
                end
                HW_WAIT: begin
                    if (cnt_zero_c) begin
                        state    <= FETCH;
                        rom_addr <= '0;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    if (is_delay_c) begin
                        if (payload_c == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= DELAY;
                        end
                    end else begin
                        tx_data  <= payload_c;
                        tx_dc    <= dc_c;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= ADVANCE;
                    end
                end
                DELAY: begin
                    if (cnt_zero_c) state <= ADVANCE;
                end
                ADVANCE: begin
                    // Last index with no end marker finishes the sequence.
                    if (rom_addr == ADDR_W'(N_ENTRIES - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Bench for lcd_init_sequencer: two instances (5-entry ROM with end marker,
// 3-entry ROM without) driven by shared start/tx_ready. A phase-timeline model
// builds the expected per-cycle outputs for each run; literal checks pin the model.
module tb_lcd_init_sequencer;

    localparam int L_CYC  = 4;
    localparam int W_CYC  = 6;
    localparam int U_TICK = 3;
    localparam int MAXLEN = 900;

    typedef struct packed {
        logic [2:0] addr;
        logic       valid;
        logic [7:0] data;
        logic       dc;
        logic       rst_n;
        logic       busy;
        logic       done;
    } exp_t;

    localparam exp_t RST_EXP = '{addr: 3'd0, valid: 1'b0, data: 8'h00, dc: 1'b0,
                                 rst_n: 1'b1, busy: 1'b0, done: 1'b0};

    logic       clk = 1'b0;
    logic       rst, start, tx_ready;
    logic [2:0] rom_addr5;
    logic [9:0] rom_data5;
    logic       tx_valid5, tx_dc5, lcd_rst_n5, busy5, done5;
    logic [7:0] tx_data5;
    logic [1:0] rom_addr3;
    logic [9:0] rom_data3;
    logic       tx_valid3, tx_dc3, lcd_rst_n3, busy3, done3;
    logic [7:0] tx_data3;

    logic [9:0] rom5 [8];
    logic [9:0] rom3 [4];
    bit         rdy  [MAXLEN];
    exp_t       tr0  [MAXLEN];
    exp_t       tr1  [MAXLEN];
    exp_t       obs0, obs1;

    logic [2:0] m_addr [2];
    logic [7:0] m_data [2];
    logic       m_dc   [2];
    logic       m_done [2];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int          cyc = 0;
    bit          cmp_en = 1'b0;
    int          cur_len = 0;
    int          first_v [2];
    int          low_cnt [2];
    int          done_cyc [2];
    int          max_addr3;
    int          acc0 [$];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data5 <= rom5[rom_addr5];
    always @(posedge clk) rom_data3 <= rom3[rom_addr3];

    lcd_init_sequencer #(.N_ENTRIES(5), .DATA_W(8), .DELAY_UNIT(U_TICK),
                         .RST_LOW_CYC(L_CYC), .RST_WAIT_CYC(W_CYC)) u_dut5 (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr5), .rom_data(rom_data5),
        .tx_valid(tx_valid5), .tx_ready(tx_ready), .tx_data(tx_data5), .tx_dc(tx_dc5),
        .lcd_rst_n(lcd_rst_n5), .busy(busy5), .done(done5));

    lcd_init_sequencer #(.N_ENTRIES(3), .DATA_W(8), .DELAY_UNIT(U_TICK),
                         .RST_LOW_CYC(L_CYC), .RST_WAIT_CYC(W_CYC)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr3), .rom_data(rom_data3),
        .tx_valid(tx_valid3), .tx_ready(tx_ready), .tx_data(tx_data3), .tx_dc(tx_dc3),
        .lcd_rst_n(lcd_rst_n3), .busy(busy3), .done(done3));

    assign obs0 = {rom_addr5, tx_valid5, tx_data5, tx_dc5, lcd_rst_n5, busy5, done5};
    assign obs1 = {1'b0, rom_addr3, tx_valid3, tx_data3, tx_dc3, lcd_rst_n3, busy3, done3};

    function automatic logic [9:0] c_e(input logic [7:0] b);  return {2'b00, b}; endfunction
    function automatic logic [9:0] d_e(input logic [7:0] b);  return {2'b01, b}; endfunction
    function automatic logic [9:0] dly(input logic [7:0] n);  return {2'b10, n}; endfunction
    localparam logic [9:0] END_E = 10'h200;

    function automatic bit rdy_at(input int t);
        return (t < MAXLEN) ? rdy[t] : 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, want);
        end
    endtask

    function automatic void put(input int k, inout int t, input exp_t e);
        if (t < cur_len) begin
            if (k == 0) tr0[t] = e;
            else        tr1[t] = e;
        end
        t++;
    endfunction

    // Expected outputs per cycle: cycle 0 holds start, reset low L, wait W, then
    // per entry: fetch + decode, then send (until ready) or N*U delay ticks, then advance.
    function automatic void gen(input int k, input int nent, input int s0);
        exp_t       e;
        int         t, i, n_tick;
        bit         fin, acc;
        logic [9:0] ent;
        e = '{addr: m_addr[k], valid: 1'b0, data: m_data[k], dc: m_dc[k],
              rst_n: 1'b1, busy: 1'b0, done: m_done[k]};
        t = 0;
        for (int j = 0; j <= s0; j++) put(k, t, e);
        e.busy = 1'b1; e.done = 1'b0; e.rst_n = 1'b0;
        for (int j = 0; j < L_CYC; j++) put(k, t, e);
        e.rst_n = 1'b1;
        for (int j = 0; j < W_CYC; j++) put(k, t, e);
        i = 0; fin = 1'b0;
        while (!fin && t < cur_len) begin
            e.addr = 3'(i);
            put(k, t, e);
            put(k, t, e);
            ent = (k == 0) ? rom5[i] : rom3[i];
            if (ent[9] && ent[7:0] == 8'h00) begin
                fin = 1'b1;
            end else begin
                if (ent[9]) begin
                    n_tick = int'(ent[7:0]) * U_TICK;
                    for (int j = 0; j < n_tick; j++) put(k, t, e);
                end else begin
                    e.valid = 1'b1; e.data = ent[7:0]; e.dc = ent[8];
                    while (t < cur_len) begin
                        acc = rdy_at(t);
                        put(k, t, e);
                        if (acc) break;
                    end
                    e.valid = 1'b0;
                end
                put(k, t, e);
                if (i == nent - 1) fin = 1'b1;
                else i++;
            end
        end
        e.busy = 1'b0; e.done = 1'b1;
        while (t < cur_len) put(k, t, e);
        m_addr[k] = e.addr; m_data[k] = e.data; m_dc[k] = e.dc; m_done[k] = 1'b1;
    endfunction

    // Per-cycle compare against the model, plus event recording for literal checks.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("trace_u5", 32'(obs0), 32'(tr0[cyc]));
            chk("trace_u3", 32'(obs1), 32'(tr1[cyc]));
            if (obs0.valid && tx_ready) acc0.push_back(cyc);
            if (obs0.valid && first_v[0] < 0) first_v[0] = cyc;
            if (obs1.valid && first_v[1] < 0) first_v[1] = cyc;
            if (!obs0.rst_n) low_cnt[0]++;
            if (!obs1.rst_n) low_cnt[1]++;
            if (obs0.done && cyc > 0 && done_cyc[0] < 0) done_cyc[0] = cyc;
            if (obs1.done && cyc > 0 && done_cyc[1] < 0) done_cyc[1] = cyc;
            if (int'(obs1.addr) > max_addr3) max_addr3 = int'(obs1.addr);
        end
    end

    task automatic run(input int len, input int extra_start);
        cur_len = len;
        gen(0, 5, 0);
        gen(1, 3, 0);
        acc0.delete();
        for (int k = 0; k < 2; k++) begin
            first_v[k] = -1; low_cnt[k] = 0; done_cyc[k] = -1;
        end
        max_addr3 = 0;
        for (int t = 0; t < len; t++) begin
            @(posedge clk); #1;
            start    = (t == 0) || (t == extra_start);
            tx_ready = rdy_at(t);
            cyc      = t;
            cmp_en   = 1'b1;
        end
        @(posedge clk); #1;
        start  = 1'b0;
        cmp_en = 1'b0;
    endtask

    task automatic set_rdy(input bit v);
        for (int i = 0; i < MAXLEN; i++) rdy[i] = v;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = 3'd0; m_data[k] = 8'h00; m_dc[k] = 1'b0; m_done[k] = 1'b0;
        end
    endtask

    task automatic basic_rom5();
        rom5 = '{c_e(8'h01), d_e(8'hAA), dly(8'd2), c_e(8'h29), END_E, END_E, END_E, END_E};
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
        basic_rom5();
        rom3 = '{c_e(8'h36), d_e(8'h48), c_e(8'h29), END_E};
        set_rdy(1'b1);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_u5", 32'(obs0), 32'(RST_EXP));
        chk("reset_u3", 32'(obs1), 32'(RST_EXP));
        @(posedge clk); #1 rst = 1'b0;

        // Basic run.
        run(40, -1);
        chk("first_valid", 32'(first_v[0]), 32'd13);
        chk("rst_low_cycles", 32'(low_cnt[0]), 32'd4);
        chk("n_bytes", 32'(acc0.size()), 32'd3);
        if (acc0.size() == 3) begin
            chk("acc_b0", 32'(acc0[0]), 32'd13);
            chk("acc_b1", 32'(acc0[1]), 32'd17);
            chk("acc_b2", 32'(acc0[2]), 32'd30);
        end
        chk("done_rise", 32'(done_cyc[0]), 32'd34);
        chk("final_addr", 32'(rom_addr5), 32'd4);
        chk("impl_end_done", 32'(done_cyc[1]), 32'd23);
        chk("impl_end_max_addr", 32'(max_addr3), 32'd2);

        // Restart from DONE.
        run(40, -1);
        chk("rerun_first_valid", 32'(first_v[0]), 32'd13);
        chk("rerun_done_rise", 32'(done_cyc[0]), 32'd34);

        // Start pulse during HW_WAIT is ignored.
        run(40, 7);
        chk("busy_start_bytes", 32'(acc0.size()), 32'd3);
        if (acc0.size() == 3) chk("busy_start_last", 32'(acc0[2]), 32'd30);

        // Backpressure on 0xAA for 5 cycles.
        for (int i = 17; i <= 21; i++) rdy[i] = 1'b0;
        run(45, -1);
        chk("bp_bytes", 32'(acc0.size()), 32'd3);
        if (acc0.size() == 3) begin
            chk("bp_acc_b1", 32'(acc0[1]), 32'd22);
            chk("bp_acc_b2", 32'(acc0[2]), 32'd35);
        end
        set_rdy(1'b1);

        // Maximum delay entry: 255 * 3 = 765 delay cycles.
        rom5 = '{c_e(8'h01), dly(8'hFF), c_e(8'h29), END_E, END_E, END_E, END_E, END_E};
        run(795, -1);
        chk("maxdly_bytes", 32'(acc0.size()), 32'd2);
        if (acc0.size() == 2) chk("maxdly_gap", 32'(acc0[1] - acc0[0]), 32'd772);
        chk("maxdly_done", 32'(done_cyc[0]), 32'd789);

        // Reset while a byte is stalled in SEND.
        basic_rom5();
        set_rdy(1'b0);
        run(15, -1);
        rst = 1'b1;
        @(negedge clk);
        chk("pre_reset_valid", 32'(tx_valid5), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midsend_reset_u5", 32'(obs0), 32'(RST_EXP));
        chk("midsend_reset_u3", 32'(obs1), 32'(RST_EXP));
        model_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", 32'({tx_valid5, lcd_rst_n5, tx_valid3, lcd_rst_n3}), 32'b0101);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
